// File: rtl/register_serial_reader.sv
// Parallel-write word register with an LSB-first serial readout port.
// A start request snapshots the stored word and emits one bit per clock, then pulses done.
module register_serial_reader #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic             start,
  output logic [WIDTH-1:0] word,
  output logic             out,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] word_q,  word_d;

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    word_d  = word_q;

    unique case (state_q)
      ST_IDLE: begin
        // load wins over start; the caller has to re-request the readout
        if (load) begin
          word_d = in;
        end else if (start) begin
          shift_d = word_q;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
        if (cnt_q == LAST_BIT) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        if (load) word_d = in;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      word_q  <= word_d;
    end
  end

  // Outputs decode straight from registered state, so reset clears them asynchronously.
  assign word  = word_q;
  assign valid = (state_q == ST_SHIFT);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = (state_q == ST_DONE);
  assign out   = valid & shift_q[0];

endmodule

// File: tb/tb_register_serial_reader.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_register_serial_reader;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic             load;
  logic             start;
  logic [WIDTH-1:0] word;
  logic             out;
  logic             valid;
  logic             busy;
  logic             done;

  int tests = 0;
  int fails = 0;

  // Reference model: stored word, queue of bits still to be emitted, pending done pulse.
  logic [WIDTH-1:0] m_word;
  bit               m_bits[$];
  bit               m_done;

  always #5 clk = ~clk;

  register_serial_reader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .in    (din),
    .load  (load),
    .start (start),
    .word  (word),
    .out   (out),
    .valid (valid),
    .busy  (busy),
    .done  (done)
  );

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic exp_v;
    logic exp_o;
    exp_v = (m_bits.size() > 0);
    exp_o = exp_v ? m_bits[0] : 1'b0;
    check({tag, ".word"},  word,  m_word);
    check({tag, ".valid"}, valid, exp_v);
    check({tag, ".busy"},  busy,  exp_v);
    check({tag, ".out"},   out,   exp_o);
    check({tag, ".done"},  done,  m_done);
  endtask

  task automatic model_reset();
    m_word = '0;
    m_bits.delete();
    m_done = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (m_bits.size() > 0) begin
      void'(m_bits.pop_front());
      if (m_bits.size() == 0) m_done = 1'b1;
    end else if (m_done) begin
      m_done = 1'b0;
      if (load) m_word = din;
    end else if (load) begin
      m_word = din;
    end else if (start) begin
      for (int k = 0; k < WIDTH; k++) m_bits.push_back(m_word[k]);
    end
  endtask

  task automatic tick(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [WIDTH-1:0] seq;
    int               lat;
    int               nvalid;
    int               ndone;

    reset = 1'b1;
    din   = '0;
    load  = 1'b0;
    start = 1'b0;
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick("idle");

    // Load gating and falling-edge immunity
    din = 16'hA5C3; load = 1'b1;
    tick("load");
    din = 16'h0000; load = 1'b0;
    tick("hold");
    din = 16'h1234; load = 1'b1;
    @(negedge clk);
    #1;
    check("negedge.word", word, 16'hA5C3);
    load = 1'b0;
    tick("after_neg");

    // Readout of A5C3 with latency and bit-order capture
    start = 1'b1;
    tick("rd_start");
    start = 1'b0;
    seq = '0; lat = 1; nvalid = 0;
    while (!done && lat < 40) begin
      if (valid && nvalid < WIDTH) seq[nvalid] = out;
      if (valid) nvalid++;
      tick("rd");
      lat++;
    end
    check("rd.seq", seq, 16'hA5C3);
    check("rd.nvalid", WIDTH'(nvalid), WIDTH'(16));
    check("rd.latency", WIDTH'(lat), WIDTH'(WIDTH + 1));
    tick("rd_idle");
    check("rd_idle.busy", busy, 1'b0);

    // start and load collide in IDLE: load wins, no readout
    din = 16'h0001; load = 1'b1; start = 1'b1;
    tick("coll");
    load = 1'b0; start = 1'b0;
    tick("coll_idle");
    check("coll.word", word, 16'h0001);
    start = 1'b1;
    tick("coll_rd");
    start = 1'b0;
    seq = '1;
    for (int k = 0; k < WIDTH; k++) begin
      seq[k] = out;
      tick("coll_rd");
    end
    check("coll.seq", seq, 16'h0001);
    tick("coll_end");

    // load during SHIFT ignored, honoured in DONE; start re-asserted at cycle 5 ignored
    din = 16'hFFFF; load = 1'b1;
    tick("ff_load");
    load = 1'b0; start = 1'b1;
    tick("ff_start");
    start = 1'b0;
    seq = '0; nvalid = 0; ndone = 0;
    for (int k = 0; k < WIDTH; k++) begin
      seq[k] = out;
      if (valid) nvalid++;
      load  = (k == 3) || (k == 9);
      start = (k == 5);
      din   = 16'h0000;
      tick("ff_rd");
    end
    load = 1'b0; start = 1'b0;
    check("ff.seq", seq, 16'hFFFF);
    check("ff.word_shift", word, 16'hFFFF);
    check("ff.nvalid", WIDTH'(nvalid), WIDTH'(16));
    check("ff.in_done", done, 1'b1);
    load = 1'b1; din = 16'h0000;
    tick("ff_done_load");
    load = 1'b0;
    check("ff.word_done", word, 16'h0000);
    for (int k = 0; k < 20; k++) begin
      if (done) ndone++;
      if (valid) nvalid++;
      tick("ff_quiet");
    end
    check("ff.no_second", WIDTH'(ndone + nvalid), WIDTH'(16));

    // Reset mid-readout
    din = 16'hFFFF; load = 1'b1;
    tick("mr_load");
    load = 1'b0; start = 1'b1;
    tick("mr_start");
    start = 1'b0;
    repeat (6) tick("mr_shift");
    reset = 1'b1;
    model_reset();
    #1;
    check_all("mr_async");
    @(posedge clk);
    #1;
    check_all("mr_held");
    reset = 1'b0;
    repeat (3) tick("mr_after");
    start = 1'b1;
    tick("mr_rd");
    start = 1'b0;
    seq = '1; nvalid = 0;
    for (int k = 0; k < WIDTH; k++) begin
      seq[k] = out;
      if (valid) nvalid++;
      tick("mr_rd");
    end
    check("mr.seq", seq, 16'h0000);
    check("mr.nvalid", WIDTH'(nvalid), WIDTH'(16));
    tick("mr_end");

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      din   = WIDTH'($urandom);
      load  = ($urandom_range(0, 3) == 0);
      start = ($urandom_range(0, 2) == 0);
      tick("rand");
    end
    load = 1'b0; start = 1'b0;
    repeat (WIDTH + 2) tick("drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_serial_reader.md
Name: register_serial_reader

Overview:
- Read-side counterpart of the single-bit REGISTER write path.
- Holds a WIDTH-bit word, written in parallel with a load strobe exactly as REGISTER is written.
- Reads the word back one bit per clock, LSB first, under a start/valid/done handshake.
- Sits between the memory bank and the serial debug/IO path; the serial consumer reconstructs the word bit by bit.

Parameters:
- WIDTH, 16, word size in bits; must be >= 2.
- CNT_W, 5, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in  input  WIDTH  parallel write data.
- load  input  1  write strobe; captures in on rising clk edge.
- start  input  1  request a serial readout of the stored word.
- word  output  WIDTH  currently stored word (parallel readback).
- out  output  1  serial data bit.
- valid  output  1  out carries a data bit this cycle.
- busy  output  1  readout in progress.
- done  output  1  one-cycle pulse after the last bit.

Behaviour:
- Reset is asynchronous and active-high, with one clock.
- While reset is high: word=0, out=0, valid=0, busy=0, done=0, state=IDLE, bit counter=0, shift register=0.
- Reset asserted mid-readout aborts immediately; no done pulse is produced.
- States:
  - IDLE: busy=0, valid=0.
  - SHIFT: busy=1, valid=1.
  - DONE: busy=0, valid=0, done=1 for exactly one cycle.
- Write path (any state except SHIFT): on a rising edge with load=1, word <= in. With load=0, word holds.
- A falling clk edge never changes any state.
- load during SHIFT is ignored: word and the shift register are unchanged.
- IDLE -> SHIFT:
  - Trigger: rising edge with start=1 and load=0.
  - Copies word into the shift register and sets the counter to 0.
- IDLE, start=1 and load=1 in the same cycle: the load is performed, start is dropped, and the state stays IDLE. The caller must re-assert start.
- SHIFT:
  - out = shift register bit 0.
  - Each rising edge shifts right by one (MSB filled with 0) and increments the counter.
  - When the counter reaches WIDTH-1 on an edge, the next state is DONE.
  - Exactly WIDTH valid cycles; bit k of word appears on cycle k.
- start during SHIFT or DONE is ignored; it is not queued.
- DONE -> IDLE unconditionally on the next edge. load is honoured in DONE.
- Latency:
  - first valid bit one cycle after start is sampled;
  - done asserted WIDTH+1 cycles after start is sampled.
- out is 0 whenever valid=0.
- The counter never exceeds WIDTH-1; no wrap-around in normal operation.

Test Plan:
- Reset mid-use: assert reset during SHIFT with word=16'hFFFF -> word=0, out=0, busy=0, done never pulses; afterwards start reads 16 zeros.
- Load gating: in=16'hA5C3, load=1, one edge -> word=16'hA5C3. Then in=16'h0000, load=0, edge -> word stays 16'hA5C3. A falling edge alone changes nothing.
- Readout: word=16'hA5C3, pulse start -> valid high for exactly 16 cycles, out sequence 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1. done pulses one cycle after the last bit, then busy=0.
- Collision: in IDLE, start=1 and load=1 with in=16'h0001 -> word=16'h0001, busy stays 0. A later start alone reads 1 followed by 15 zeros.
- Load during SHIFT: during a 16'hFFFF readout, drive load=1, in=16'h0000 -> all 16 out bits are 1 and word stays 16'hFFFF. The same load in DONE updates word to 16'h0000.
- Ignored start: re-assert start at readout cycle 5 -> still exactly 16 valid cycles and a single done pulse; no second readout follows.
